// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes a bouncing raw input and accepts a new level only after it holds for STABLE_CYCLES clocks
module switch_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic db_level,
  output logic busy
);
  // Encoding chosen so bit 1 is the accepted level and bit 0 marks a qualification in progress
  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] WAIT1 = 2'b01;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] WAIT0 = 2'b11;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(STABLE_CYCLES - 1);
  logic             r_s1;
  logic             r_s2;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_zero;
  assign w_cnt_zero = r_cnt == '0;
  // Two-flop synchronizer; only r_s2 is ever seen by the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
    end
  end
  // Next state and counter; a revert of r_s2 beats an expiring counter, and the counter stops at zero
  always_comb begin
    w_state_nxt = ZERO;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ZERO: begin
        w_state_nxt = r_s2 ? WAIT1 : ZERO;
        w_cnt_nxt   = r_s2 ? LOAD : r_cnt;
      end
      WAIT1: begin
        w_state_nxt = !r_s2 ? ZERO : (w_cnt_zero ? ONE : WAIT1);
        w_cnt_nxt   = (r_s2 && !w_cnt_zero) ? r_cnt - 1'b1 : r_cnt;
      end
      ONE: begin
        w_state_nxt = !r_s2 ? WAIT0 : ONE;
        w_cnt_nxt   = !r_s2 ? LOAD : r_cnt;
      end
      WAIT0: begin
        w_state_nxt = r_s2 ? ONE : (w_cnt_zero ? ZERO : WAIT0);
        w_cnt_nxt   = (!r_s2 && !w_cnt_zero) ? r_cnt - 1'b1 : r_cnt;
      end
      default: w_state_nxt = ZERO;
    endcase
  end
  // State and counter registers; reset aborts any qualification straight to ZERO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ZERO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  assign db_level = r_state[1];
  assign busy     = r_state[0];
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions a raw, asynchronous, bouncing input such as a push-button into a clean, synchronous level, `db_level`.
- Sits directly upstream of the edge-detector stage, which turns `db_level` into a one-cycle pulse.
- Internals: a 2-flop synchronizer, a 4-state Moore FSM and a down-counter.
- `db_level` changes only after the synchronized input holds a new value for `STABLE_CYCLES` consecutive clocks.

Parameters:
- STABLE_CYCLES, default 1000000, number of consecutive stable clocks required to accept a new level (10 ms at 100 MHz). Legal range >= 1.
- CNT_W, default $clog2(STABLE_CYCLES+1), counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  raw switch input. Asynchronous to clk and may bounce.
- db_level  output  1  debounced level, synchronous to clk.
- busy  output  1  high while a candidate level change is being qualified (WAIT1/WAIT0).

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- On reset: sync flops = 0, state = ZERO, counter = 0, db_level = 0, busy = 0. Reset asserted mid-qualification aborts immediately to ZERO with no output glitch to 1.
- Synchronizer: in -> s1 -> s2 on each rising edge. in_s = s2. The FSM never uses `in` directly.
- FSM states: ZERO, WAIT1, ONE, WAIT0. All transitions occur on the rising edge of clk.
- ZERO:
  - in_s=1 -> WAIT1, counter <= STABLE_CYCLES-1.
  - otherwise stay.
- WAIT1:
  - in_s=0 -> ZERO (abort; counter value don't-care).
  - else counter==0 -> ONE.
  - else counter <= counter-1.
- ONE:
  - in_s=0 -> WAIT0, counter <= STABLE_CYCLES-1.
  - otherwise stay.
- WAIT0:
  - in_s=1 -> ONE (abort).
  - else counter==0 -> ZERO.
  - else counter <= counter-1.
- Outputs are Moore, decoded from the state register only (no path from in or in_s):
  - db_level = 1 in ONE and WAIT0; 0 in ZERO and WAIT1.
  - busy = 1 in WAIT1 and WAIT0.
- Latency: for a clean step on `in`, first sampled by s1 at edge k, db_level changes after edge k+STABLE_CYCLES+2. This is identical for rising and falling steps.
- Glitch rejection: any excursion of in_s lasting <= STABLE_CYCLES clocks returns the FSM to its previous stable state without changing db_level.
- Simultaneous counter==0 and in_s reverting in WAIT1/WAIT0: the abort wins. State returns to ZERO or ONE respectively.
- Counter never wraps: it is loaded only on entry to a WAIT state and decremented only while it is nonzero.
- STABLE_CYCLES=1: WAIT state lasts exactly one cycle when in_s is stable.
- Unreachable or illegal state encoding recovers to ZERO on the next edge.

Test Plan:
All scenarios use STABLE_CYCLES=4.
- Reset: assert rst mid-cycle with in=1 -> db_level=0, busy=0 immediately (asynchronous); after release, db_level rises only after the full qualification.
- Clean rise: in 0->1 sampled at edge 0 and held -> busy=1 after edge 2, db_level=1 after edge 6, busy=0 after edge 6. Clean fall mirrors this: db_level=0 exactly 6 edges after the sampling edge.
- Bounce: in toggles 1,0,1,1,0,1 on successive edges, then holds 1 -> db_level stays 0 through the bounce and rises 6 edges after the last 0->1 sample; busy toggles accordingly.
- Short glitch: with db_level=1, in=0 for 3 cycles then back to 1 -> db_level remains 1 throughout; busy high for the glitch duration plus sync delay; FSM returns to ONE.
- Boundary abort: in_s reverts on exactly the edge where the WAIT1 counter==0 -> FSM goes to ZERO and db_level never asserts.
- Downstream integration: connect db_level to the edge detector with a bouncy press -> exactly one detector output pulse per accepted press; random bounce with <= 4-cycle glitches -> no extra pulses.
